// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: scalar accesses win each slot, vector bursts fill idle slots.
// Optional STARVE_GUARD_EN forces a vector slot after MAX_WAIT consecutive losses to scalar.
module dmem_arbiter #(
    parameter int LEN_W     = 6,
    parameter int MEM_DEPTH = 121,
    parameter int MAX_WAIT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_req,
    input  logic             s_we,
    input  logic [31:0]      s_addr,
    input  logic [31:0]      s_wdata,
    output logic             s_gnt,
    output logic [31:0]      s_rdata,
    output logic             s_rvalid,
    input  logic             v_start,
    input  logic             v_we,
    input  logic [31:0]      v_base,
    input  logic [31:0]      v_stride,
    input  logic [LEN_W-1:0] v_len,
    input  logic [31:0]      v_wdata,
    output logic             v_wready,
    output logic [LEN_W-1:0] v_idx,
    output logic [31:0]      v_rdata,
    output logic             v_rvalid,
    output logic [LEN_W-1:0] v_ridx,
    output logic             v_busy,
    output logic             v_done,
    output logic             err,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_write_en,
    output logic             mem_read,
    input  logic [31:0]      mem_read_data
);

    typedef enum logic {IDLE, VBURST} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      addr_reg, stride_reg, last_addr_reg;
    logic [LEN_W-1:0] len_reg, idx_reg, v_ridx_reg;
    logic             we_reg;
    logic [31:0]      s_rdata_reg, v_rdata_reg;
    logic             s_rvalid_reg, v_rvalid_reg, v_done_reg, err_reg;

    logic             force_vec, vec_issue, slot_active, slot_we, in_range, last_elem, burst_start;
    logic [31:0]      slot_addr;

`ifdef STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt_reg;

    assign force_vec = (state_reg == VBURST) && (wait_cnt_reg == WAIT_W'(MAX_WAIT));

    // Counts consecutive burst cycles lost to the scalar port.
    always_ff @(posedge clk) begin
        if (!rst_n || state_reg != VBURST || vec_issue)
            wait_cnt_reg <= '0;
        else if (s_gnt)
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
`else
    assign force_vec = (MAX_WAIT < 0);
`endif

    always_comb begin
        s_gnt          = s_req && !force_vec;
        vec_issue      = (state_reg == VBURST) && !s_gnt;
        slot_active    = s_gnt || vec_issue;
        slot_addr      = s_gnt ? s_addr : addr_reg;
        slot_we        = s_gnt ? s_we : we_reg;
        in_range       = slot_addr < 32'(MEM_DEPTH);
        last_elem      = idx_reg == (len_reg - LEN_W'(1));
        burst_start    = (state_reg == IDLE) && v_start && (v_len != '0);
        // Out-of-range slots are consumed without touching the memory.
        mem_read       = rst_n && slot_active && !slot_we && in_range;
        mem_write_en   = rst_n && slot_active && slot_we && in_range;
        mem_addr       = slot_active ? slot_addr : last_addr_reg;
        mem_write_data = s_gnt ? s_wdata : v_wdata;
        v_wready       = vec_issue && we_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (burst_start) state_next = VBURST;
            VBURST:  if (vec_issue && last_elem) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            stride_reg    <= '0;
            len_reg       <= '0;
            we_reg        <= 1'b0;
            idx_reg       <= '0;
            last_addr_reg <= '0;
            s_rdata_reg   <= '0;
            s_rvalid_reg  <= 1'b0;
            v_rdata_reg   <= '0;
            v_rvalid_reg  <= 1'b0;
            v_ridx_reg    <= '0;
            v_done_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            s_rvalid_reg <= s_gnt && !s_we;
            if (s_gnt && !s_we)
                s_rdata_reg <= in_range ? mem_read_data : '0;
            v_rvalid_reg <= vec_issue && !we_reg;
            if (vec_issue && !we_reg) begin
                v_rdata_reg <= in_range ? mem_read_data : '0;
                v_ridx_reg  <= idx_reg;
            end
            v_done_reg <= ((state_reg == IDLE) && v_start && (v_len == '0)) ||
                          (vec_issue && last_elem);
            if (slot_active && !in_range)
                err_reg <= 1'b1;
            if (slot_active)
                last_addr_reg <= slot_addr;
            if (burst_start) begin
                addr_reg   <= v_base;
                stride_reg <= v_stride;
                len_reg    <= v_len;
                we_reg     <= v_we;
                idx_reg    <= '0;
            end else if (vec_issue) begin
                addr_reg <= addr_reg + stride_reg;
                idx_reg  <= idx_reg + LEN_W'(1);
            end
        end
    end

    assign s_rdata  = s_rdata_reg;
    assign s_rvalid = s_rvalid_reg;
    assign v_rdata  = v_rdata_reg;
    assign v_rvalid = v_rvalid_reg;
    assign v_ridx   = v_ridx_reg;
    assign v_idx    = idx_reg;
    assign v_busy   = (state_reg == VBURST);
    assign v_done   = v_done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a slot-level model.
module tb_dmem_arbiter;

    localparam int DEPTH    = 121;
    localparam int MAX_WAIT = 4;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        s_req = 1'b0, s_we = 1'b0, s_gnt, s_rvalid;
    logic [31:0] s_addr = '0, s_wdata = '0, s_rdata;
    logic        v_start = 1'b0, v_we = 1'b0, v_wready, v_rvalid, v_busy, v_done, err;
    logic [31:0] v_base = '0, v_stride = '0, v_wdata = '0, v_rdata;
    logic [5:0]  v_len = '0, v_idx, v_ridx;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .v_start(v_start), .v_we(v_we), .v_base(v_base), .v_stride(v_stride),
        .v_len(v_len), .v_wdata(v_wdata), .v_wready(v_wready), .v_idx(v_idx),
        .v_rdata(v_rdata), .v_rvalid(v_rvalid), .v_ridx(v_ridx),
        .v_busy(v_busy), .v_done(v_done), .err(err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    // Memory attached to the DUT; out-of-range reads return junk the DUT must suppress.
    logic [31:0] tb_mem [0:DEPTH-1];
    always @(posedge clk)
        if (mem_write_en && mem_addr < 32'(DEPTH))
            tb_mem[mem_addr[6:0]] <= mem_write_data;
    assign mem_read_data = (mem_addr < 32'(DEPTH)) ? tb_mem[mem_addr[6:0]] : 32'hDEAD_BEEF;

    // Reference model state
    logic [31:0] ref_mem [0:DEPTH-1];
    bit          m_busy, m_we, err_e;
    int          m_idx, m_len, m_wait;
    logic [31:0] m_addr, m_stride;
    int          tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'(DEPTH);
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        bit          gnt_e, vis_e, busy_pre, act_we;
        bit          exp_srv = 0, exp_vrv = 0, exp_done = 0;
        logic [31:0] a, exp_srd = '0, exp_vrd = '0, wd;
        int          exp_vridx = 0;
        #1;
        if (!rst_n) begin
            chk("rst_mem_read", 32'(mem_read), 0);
            chk("rst_mem_we", 32'(mem_write_en), 0);
            @(posedge clk); #1;
            m_busy = 0; m_idx = 0; m_wait = 0; err_e = 0;
            chk("rst_s_rdata", s_rdata, 0);   chk("rst_s_rvalid", 32'(s_rvalid), 0);
            chk("rst_v_rdata", v_rdata, 0);   chk("rst_v_rvalid", 32'(v_rvalid), 0);
            chk("rst_v_ridx", 32'(v_ridx), 0); chk("rst_v_idx", 32'(v_idx), 0);
            chk("rst_v_busy", 32'(v_busy), 0); chk("rst_v_done", 32'(v_done), 0);
            chk("rst_err", 32'(err), 0);
            return;
        end
        busy_pre = m_busy;
        gnt_e = s_req && !(GUARD && m_busy && m_wait == MAX_WAIT);
        vis_e = m_busy && !gnt_e;
        chk("s_gnt", 32'(s_gnt), 32'(gnt_e));
        chk("v_wready", 32'(v_wready), 32'(vis_e && m_we));
        chk("v_busy", 32'(v_busy), 32'(m_busy));
        if (m_busy) chk("v_idx", 32'(v_idx), 32'(m_idx[5:0]));
        if (gnt_e || vis_e) begin
            a      = gnt_e ? s_addr : m_addr;
            act_we = gnt_e ? s_we : m_we;
            wd     = gnt_e ? s_wdata : v_wdata;
            if (in_rng(a)) begin
                chk("mem_addr", mem_addr, a);
                chk("mem_read", 32'(mem_read), 32'(!act_we));
                chk("mem_we", 32'(mem_write_en), 32'(act_we));
                if (act_we) begin
                    chk("mem_wdata", mem_write_data, wd);
                    ref_mem[a[6:0]] = wd;
                end
            end else begin
                chk("oor_mem_read", 32'(mem_read), 0);
                chk("oor_mem_we", 32'(mem_write_en), 0);
                err_e = 1;
            end
            if (gnt_e && !act_we) begin
                exp_srv = 1;
                exp_srd = in_rng(a) ? ref_mem[a[6:0]] : 32'h0;
            end
            if (vis_e) begin
                if (!act_we) begin
                    exp_vrv   = 1;
                    exp_vrd   = in_rng(a) ? ref_mem[a[6:0]] : 32'h0;
                    exp_vridx = m_idx;
                end
                m_addr = m_addr + m_stride;
                m_idx++;
                m_wait = 0;
                if (m_idx == m_len) begin
                    m_busy   = 0;
                    exp_done = 1;
                end
            end else if (busy_pre) begin
                m_wait++;
            end
        end else begin
            chk("idle_mem_read", 32'(mem_read), 0);
            chk("idle_mem_we", 32'(mem_write_en), 0);
        end
        if (!busy_pre && v_start) begin
            if (v_len == 0) exp_done = 1;
            else begin
                m_busy = 1; m_we = v_we; m_addr = v_base; m_stride = v_stride;
                m_len = int'(v_len); m_idx = 0; m_wait = 0;
            end
        end
        @(posedge clk); #1;
        chk("s_rvalid", 32'(s_rvalid), 32'(exp_srv));
        if (exp_srv) chk("s_rdata", s_rdata, exp_srd);
        chk("v_rvalid", 32'(v_rvalid), 32'(exp_vrv));
        if (exp_vrv) begin
            chk("v_rdata", v_rdata, exp_vrd);
            chk("v_ridx", 32'(v_ridx), 32'(exp_vridx));
        end
        chk("v_done", 32'(v_done), 32'(exp_done));
        chk("err", 32'(err), 32'(err_e));
    endtask

    task automatic scalar(input bit we, input logic [31:0] addr, input logic [31:0] data);
        s_req = 1'b1; s_we = we; s_addr = addr; s_wdata = data;
        step();
        s_req = 1'b0;
    endtask

    task automatic start_v(input bit we, input logic [31:0] base, input logic [31:0] stride,
                           input logic [5:0] len);
        v_start = 1'b1; v_we = we; v_base = base; v_stride = stride; v_len = len;
        step();
        v_start = 1'b0;
    endtask

    task automatic run_burst();
        for (int n = 0; n < 100 && m_busy; n++) begin
            v_wdata = 32'hC000_0000 | 32'(m_idx);
            step();
        end
        chk("burst_end_busy", 32'(v_busy), 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = (i < 4) ? 32'(i) : $urandom;
            ref_mem[i] = tb_mem[i];
        end
        m_busy = 0; m_idx = 0; m_wait = 0; err_e = 0; m_we = 0; m_len = 0;
        m_addr = '0; m_stride = '0;

        rst_n = 1'b0; step(); step(); rst_n = 1'b1;

        scalar(1'b1, 32'd5, 32'hA5);
        scalar(1'b0, 32'd5, 32'h0);
        chk("scalar_readback_a5", s_rdata, 32'hA5);

        start_v(1'b0, 32'd0, 32'd1, 6'd4);
        run_burst();

        start_v(1'b1, 32'd10, 32'd2, 6'd3);
        run_burst();
        for (int k = 0; k < 3; k++) begin
            scalar(1'b0, 32'(10 + 2 * k), 32'h0);
            chk("vstore_readback", s_rdata, 32'hC000_0000 | 32'(k));
        end

        // Scalar traffic held through a burst: the vector stalls (or is forced under the guard).
        start_v(1'b0, 32'd20, 32'd1, 6'd3);
        for (int n = 0; n < 16; n++) begin
            s_req = 1'b1; s_we = 1'b0; s_addr = 32'($urandom_range(40, 100));
            step();
        end
        s_req = 1'b0;
        run_burst();

        start_v(1'b0, 32'd119, 32'd1, 6'd3);
        run_burst();
        chk("oor_err_sticky", 32'(err), 1);

        start_v(1'b0, 32'd30, 32'd1, 6'd5);
        step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        step(); step();
        chk("busy_after_rst", 32'(v_busy), 0);

        // Zero-length burst and back-to-back start on the done cycle.
        start_v(1'b0, 32'd0, 32'd1, 6'd0);
        start_v(1'b0, 32'd1, 32'd1, 6'd2);
        run_burst();

        for (int n = 0; n < 400; n++) begin
            int st;
            s_req   = ($urandom_range(0, 9) < 3);
            s_we    = $urandom_range(0, 1) == 1;
            s_addr  = 32'($urandom_range(0, 125));
            s_wdata = $urandom;
            v_start = ($urandom_range(0, 3) == 0);
            v_we    = $urandom_range(0, 1) == 1;
            v_base  = 32'($urandom_range(0, 130));
            st      = int'($urandom_range(0, 6)) - 3;
            v_stride = 32'(st);
            v_len   = 6'($urandom_range(0, 7));
            v_wdata = $urandom;
            step();
        end
        s_req = 1'b0; v_start = 1'b0;
        run_burst();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
